// File: rtl/video_line_fetch_ctrl.sv
// Ping-pong line-buffer fetch scheduler: turns vsync/de timing into line fetch requests.
// Define FETCH_ERR_CNT_EN to add the saturating underflow_cnt[15:0] output.
module video_line_fetch_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        rgb_clk,
  input  logic        rgb_rst_n,
  input  logic        ctrl_en,
  input  logic        rgb_vs,
  input  logic        rgb_de,
  output logic        fetch_req,
  output logic [10:0] fetch_line,
  output logic        fetch_bank,
  input  logic        fetch_ack,
  input  logic        fetch_done,
  output logic        rd_bank,
  output logic        underflow,
  output logic        underflow_sticky
`ifdef FETCH_ERR_CNT_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DONE,
    ST_NEXT
  } state_t;

  typedef struct packed {
    logic [10:0] line;
    logic        bank;
  } fetch_t;

  localparam logic [11:0] V_LIM  = 12'(V_ACTIVE);
  localparam logic [10:0] LN_MAX = 11'(V_ACTIVE - 1);

  if (H_ACTIVE < 1 || V_ACTIVE < 2 || V_ACTIVE > 2048) begin : g_cfg_check
    $error("video_line_fetch_ctrl: H_ACTIVE must be >= 1 and V_ACTIVE in 2..2048");
  end

  state_t      r_state;
  logic        r_vs_d;
  logic        r_de_d;
  logic        r_fetch_req;
  logic [10:0] r_fetch_line;
  logic        r_fetch_bank;
  logic        r_rd_bank;
  logic        r_underflow;
  logic        r_underflow_sticky;
  logic [1:0]  r_bank_valid;
  fetch_t      r_q [2];
  logic [1:0]  r_q_cnt;
  logic [10:0] r_ln;
  logic        r_frame_en;
  logic        r_fs_pend;
  logic        r_fs_pend_en;

  logic        w_fs;
  logic        w_ls;
  logic        w_le;
  logic        w_busy;
  logic        w_restart;
  logic        w_restart_en;
  logic        w_pop;
  logic        w_push;
  logic        w_underflow;
  logic [11:0] w_ln_p2;
  fetch_t      w_q_n [2];
  logic [1:0]  w_q_cnt_n;
  logic [1:0]  w_bank_valid_n;

  assign w_fs   = (rgb_vs == VS_POL) && (r_vs_d != VS_POL);
  assign w_ls   = rgb_de && !r_de_d;
  assign w_le   = !rgb_de && r_de_d;
  assign w_busy = (r_state == ST_REQ) || (r_state == ST_WAIT_DONE);

  // A frame start seen mid-transfer is parked until the transfer retires in NEXT.
  assign w_restart    = (w_fs && !w_busy) || (r_fs_pend && (r_state == ST_NEXT));
  assign w_restart_en = w_fs ? ctrl_en : r_fs_pend_en;

  assign w_pop       = ((r_state == ST_IDLE) || (r_state == ST_NEXT)) && !w_restart
                       && (r_q_cnt != 2'd0);
  assign w_ln_p2     = {1'b0, r_ln} + 12'd2;
  assign w_push      = w_le && r_frame_en && (w_ln_p2 < V_LIM);
  assign w_underflow = w_ls && !r_bank_valid[r_rd_bank];

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_q_n     = r_q;
    w_q_cnt_n = r_q_cnt;
    if (w_pop) begin
      w_q_n[0]  = r_q[1];
      w_q_cnt_n = r_q_cnt - 2'd1;
    end
    if (w_push && (w_q_cnt_n != 2'd2)) begin
      w_q_n[w_q_cnt_n[0]] = '{line: w_ln_p2[10:0], bank: r_rd_bank};
      w_q_cnt_n           = w_q_cnt_n + 2'd1;
    end
    if (w_restart) begin
      w_q_n[0]  = '{line: 11'd0, bank: 1'b0};
      w_q_n[1]  = '{line: 11'd1, bank: 1'b1};
      w_q_cnt_n = w_restart_en ? 2'd2 : 2'd0;
    end
  end

  // Line-end clear is applied after the done set so it wins on a same-bank collision.
  always_comb begin
    w_bank_valid_n = r_bank_valid;
    if ((r_state == ST_WAIT_DONE) && fetch_done && !r_fs_pend && !w_fs) begin
      w_bank_valid_n[r_fetch_bank] = 1'b1;
    end
    if (w_le) begin
      w_bank_valid_n[r_rd_bank] = 1'b0;
    end
    if (w_restart) begin
      w_bank_valid_n = 2'b00;
    end
  end

  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      r_state      <= ST_IDLE;
      r_fetch_req  <= 1'b0;
      r_fetch_line <= '0;
      r_fetch_bank <= 1'b0;
      r_fs_pend    <= 1'b0;
      r_fs_pend_en <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (w_fs && w_busy) begin
        r_fs_pend    <= 1'b1;
        r_fs_pend_en <= ctrl_en;
      end else if (w_restart) begin
        r_fs_pend <= 1'b0;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state      <= ST_REQ;
            r_fetch_req  <= 1'b1;
            r_fetch_line <= r_q[0].line;
            r_fetch_bank <= r_q[0].bank;
          end
        end
        ST_REQ: begin
          if (fetch_ack) begin
            r_state     <= ST_WAIT_DONE;
            r_fetch_req <= 1'b0;
          end
        end
        ST_WAIT_DONE: begin
          if (fetch_done) begin
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (w_pop) begin
            r_state      <= ST_REQ;
            r_fetch_req  <= 1'b1;
            r_fetch_line <= r_q[0].line;
            r_fetch_bank <= r_q[0].bank;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      r_vs_d             <= !VS_POL;
      r_de_d             <= 1'b0;
      // NOTE: the two queue slots are plain flops, so they are reset like any other state.
      r_q[0]             <= '0;
      r_q[1]             <= '0;
      r_q_cnt            <= 2'd0;
      r_bank_valid       <= 2'b00;
      r_rd_bank          <= 1'b0;
      r_ln               <= '0;
      r_frame_en         <= 1'b0;
      r_underflow        <= 1'b0;
      r_underflow_sticky <= 1'b0;
    end else begin
      r_vs_d       <= rgb_vs;
      r_de_d       <= rgb_de;
      r_q          <= w_q_n;
      r_q_cnt      <= w_q_cnt_n;
      r_bank_valid <= w_bank_valid_n;
      r_underflow  <= w_underflow;
      if (w_underflow) begin
        r_underflow_sticky <= 1'b1;
      end
      if (w_restart) begin
        r_rd_bank  <= 1'b0;
        r_ln       <= '0;
        r_frame_en <= w_restart_en;
      end else if (w_le) begin
        r_rd_bank <= ~r_rd_bank;
        if (r_ln < LN_MAX) begin
          r_ln <= r_ln + 11'd1;
        end
      end
    end
  end

`ifdef FETCH_ERR_CNT_EN
  logic [15:0] r_underflow_cnt;

  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      r_underflow_cnt <= '0;
    end else if (w_underflow && (r_underflow_cnt != 16'hFFFF)) begin
      r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end
  end

  assign underflow_cnt = r_underflow_cnt;
`endif

  assign fetch_req        = r_fetch_req;
  assign fetch_line       = r_fetch_line;
  assign fetch_bank       = r_fetch_bank;
  assign rd_bank          = r_rd_bank;
  assign underflow        = r_underflow;
  assign underflow_sticky = r_underflow_sticky;

endmodule

// File: tb/tb_video_line_fetch_ctrl.sv
// Directed + randomized bench for video_line_fetch_ctrl with a behavioural memory reader
// and a frame-level model of the expected fetch sequence and underflow count.
module tb_video_line_fetch_ctrl;

  localparam int H   = 16;
  localparam int V   = 12;
  localparam bit VSP = 1'b1;

  logic        rgb_clk = 1'b0;
  logic        rgb_rst_n, ctrl_en, rgb_vs, rgb_de, fetch_ack, fetch_done;
  logic        fetch_req, fetch_bank, rd_bank, underflow, underflow_sticky;
  logic [10:0] fetch_line;
`ifdef FETCH_ERR_CNT_EN
  logic [15:0] underflow_cnt;
  int          exp_cnt = 0;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reader model knobs/state and observation counters.
  logic        ack_hold = 1'b0, done_manual = 1'b0, force_done = 1'b0, acked = 1'b0;
  logic        stab_mon = 1'b0;
  int          ack_dly = 0, done_dly = 3, ack_wait = 0, done_cnt = 0;
  int          uf_seen = 0, req_cycles = 0, unstable = 0, exp_uf = 0;
  logic [11:0] req_log[$];
  logic [11:0] exp_log[$];

  video_line_fetch_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .VS_POL(VSP)) dut (
    .rgb_clk          (rgb_clk),
    .rgb_rst_n        (rgb_rst_n),
    .ctrl_en          (ctrl_en),
    .rgb_vs           (rgb_vs),
    .rgb_de           (rgb_de),
    .fetch_req        (fetch_req),
    .fetch_line       (fetch_line),
    .fetch_bank       (fetch_bank),
    .fetch_ack        (fetch_ack),
    .fetch_done       (fetch_done),
    .rd_bank          (rd_bank),
    .underflow        (underflow),
    .underflow_sticky (underflow_sticky)
`ifdef FETCH_ERR_CNT_EN
    ,
    .underflow_cnt    (underflow_cnt)
`endif
  );

  always #5 rgb_clk = ~rgb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: apply timing inputs, let the reader react to outputs seen at this
  // falling edge, record observations, then advance to the next falling edge.
  task automatic cyc(input logic de, input logic vs);
    rgb_de     = de;
    rgb_vs     = vs;
    fetch_ack  = 1'b0;
    fetch_done = force_done;
    if (force_done) done_cnt = 0;
    if (!done_manual && done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) fetch_done = 1'b1;
    end
    if (!fetch_req) begin
      acked    = 1'b0;
      ack_wait = ack_dly;
    end else if (!acked && !ack_hold) begin
      if (ack_wait == 0) begin
        fetch_ack = 1'b1;
        acked     = 1'b1;
        done_cnt  = done_dly;
        req_log.push_back({fetch_line, fetch_bank});
      end else begin
        ack_wait--;
      end
    end
    if (underflow) uf_seen++;
    if (fetch_req) req_cycles++;
    if (stab_mon && (fetch_req !== 1'b1 || fetch_line !== 11'd0 || fetch_bank !== 1'b0))
      unstable++;
    @(negedge rgb_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, !VSP);
  endtask

  task automatic vs_pulse();
    cyc(1'b0, VSP);
    cyc(1'b0, VSP);
    cyc(1'b0, !VSP);
  endtask

  task automatic lines(input int n, input int hb);
    for (int l = 0; l < n; l++) begin
      idle(hb);
      for (int p = 0; p < H; p++) cyc(1'b1, !VSP);
    end
  endtask

  task automatic frame(input int hb);
    vs_pulse();
    idle(20);
    lines(V, hb);
    idle(2 * hb);
  endtask

  // Frame-level expectation: an enabled frame fetches every line once, banks alternating,
  // with no underflow; a disabled frame fetches nothing and underflows on every line.
  function automatic void build_model(input logic en);
    exp_log.delete();
    if (en) for (int i = 0; i < V; i++) exp_log.push_back({11'(i), 1'(i % 2)});
    exp_uf = en ? 0 : V;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rgb_rst_n = 1'b0; ctrl_en = 1'b1; rgb_vs = !VSP; rgb_de = 1'b0;
    fetch_ack = 1'b0; fetch_done = 1'b0;
    repeat (3) @(negedge rgb_clk);

    // Reset state
    check("rst_req",    32'(fetch_req), 32'd0);
    check("rst_line",   32'(fetch_line), 32'd0);
    check("rst_bank",   32'(fetch_bank), 32'd0);
    check("rst_rdbank", 32'(rd_bank), 32'd0);
    check("rst_uf",     32'(underflow), 32'd0);
    check("rst_sticky", 32'(underflow_sticky), 32'd0);
    rgb_rst_n = 1'b1;

    // No request before the first frame start; every line start underflows.
    req_cycles = 0; uf_seen = 0;
    lines(3, 10);
    idle(4);
    check("nofs_req",    req_cycles, 0);
    check("nofs_uf",     uf_seen, 3);
    check("nofs_sticky", 32'(underflow_sticky), 32'd1);
`ifdef FETCH_ERR_CNT_EN
    exp_cnt = 3;
    check("nofs_cnt", 32'(underflow_cnt), exp_cnt);
`endif

    // Randomized frames against the frame-level model.
    for (int f = 0; f < 6; f++) begin
      logic en;
      int   hb;
      en       = (f == 0) ? 1'b1 : (f == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      hb       = $urandom_range(8, 15);
      ack_dly  = $urandom_range(0, 3);
      done_dly = $urandom_range(1, 10);
      ctrl_en  = en;
      build_model(en);
      req_log.delete(); uf_seen = 0;
      frame(hb);
      check($sformatf("frm%0d_nreq", f), req_log.size(), exp_log.size());
      for (int i = 0; i < exp_log.size(); i++)
        check($sformatf("frm%0d_req%0d", f, i),
              32'((i < req_log.size()) ? req_log[i] : 12'hFFF), 32'(exp_log[i]));
      check($sformatf("frm%0d_uf", f), uf_seen, exp_uf);
      if (en) check($sformatf("frm%0d_rdbank", f), 32'(rd_bank), 32'(V % 2));
      check($sformatf("frm%0d_sticky", f), 32'(underflow_sticky), 32'd1);
`ifdef FETCH_ERR_CNT_EN
      exp_cnt += exp_uf;
      check($sformatf("frm%0d_cnt", f), 32'(underflow_cnt), exp_cnt);
`endif
    end

    // Ack withheld: request stays put, every line underflows, a frame start mid-REQ
    // does not drop the request, and the restart follows the retired transfer.
    ctrl_en = 1'b1; ack_dly = 0; done_dly = 3; ack_hold = 1'b1;
    req_log.delete(); uf_seen = 0; unstable = 0;
    vs_pulse();
    for (int i = 0; i < 10 && !fetch_req; i++) idle(1);
    check("hold_req_up", 32'(fetch_req), 32'd1);
    stab_mon = 1'b1;
    lines(3, 10);
    idle(4);
    vs_pulse();
    idle(10);
    stab_mon = 1'b0;
    check("hold_stable", unstable, 0);
    check("hold_uf",     uf_seen, 3);
    check("hold_noack",  req_log.size(), 0);
    ack_hold = 1'b0;
    idle(40);
    check("hold_nreq",  req_log.size(), 3);
    check("hold_req0",  32'((req_log.size() > 0) ? req_log[0] : 12'hFFF), 32'({11'd0, 1'b0}));
    check("hold_req1",  32'((req_log.size() > 1) ? req_log[1] : 12'hFFF), 32'({11'd0, 1'b0}));
    check("hold_req2",  32'((req_log.size() > 2) ? req_log[2] : 12'hFFF), 32'({11'd1, 1'b1}));
    check("hold_rdbank", 32'(rd_bank), 32'd0);

    // Frame start while waiting for done of line 6: done is discarded, restart follows.
    ack_dly = 1; done_dly = 3;
    req_log.delete();
    vs_pulse();
    idle(20);
    lines(5, 10);
    done_manual = 1'b1;
    for (int i = 0; i < 20 && req_log.size() < 7; i++) idle(1);
    idle(2);
    check("wd_nreq",  req_log.size(), 7);
    check("wd_last",  32'((req_log.size() > 0) ? req_log[req_log.size() - 1] : 12'hFFF),
          32'({11'd6, 1'b0}));
    vs_pulse();
    req_cycles = 0;
    idle(5);
    check("wd_noreq", req_cycles, 0);
    req_log.delete();
    force_done = 1'b1;
    idle(1);
    force_done = 1'b0; done_manual = 1'b0;
    idle(30);
    check("wd_nreq2",  req_log.size(), 2);
    check("wd_req0",   32'((req_log.size() > 0) ? req_log[0] : 12'hFFF), 32'({11'd0, 1'b0}));
    check("wd_req1",   32'((req_log.size() > 1) ? req_log[1] : 12'hFFF), 32'({11'd1, 1'b1}));
    check("wd_rdbank", 32'(rd_bank), 32'd0);
    check("wd_valid",  32'(dut.r_bank_valid), 32'd3);
    uf_seen = 0;
    lines(V, 10);
    idle(20);
    check("wd_total", req_log.size(), V);
    check("wd_uf",    uf_seen, 0);

    // Line end and fetch_done on the same bank in one cycle: the clear wins.
    ack_dly = 0; ack_hold = 1'b1; done_manual = 1'b1; uf_seen = 0;
    vs_pulse();
    idle(10);
    check("col_req_up", 32'(fetch_req), 32'd1);
    idle(10);
    for (int p = 0; p < H - 3; p++) cyc(1'b1, !VSP);
    ack_hold = 1'b0;
    for (int p = 0; p < 3; p++) cyc(1'b1, !VSP);
    force_done = 1'b1;
    cyc(1'b0, !VSP);
    force_done = 1'b0;
    check("col_valid0", 32'(dut.r_bank_valid[0]), 32'd0);
    check("col_rdbank", 32'(rd_bank), 32'd1);
    check("col_uf",     uf_seen, 1);
    done_manual = 1'b0;
    idle(40);

    // Reset in the middle of a request.
    ack_hold = 1'b1;
    vs_pulse();
    for (int i = 0; i < 10 && !fetch_req; i++) idle(1);
    check("mrst_req_up", 32'(fetch_req), 32'd1);
    check("mrst_sticky_up", 32'(underflow_sticky), 32'd1);
    #2 rgb_rst_n = 1'b0;
    #1;
    check("mrst_req",    32'(fetch_req), 32'd0);
    check("mrst_sticky", 32'(underflow_sticky), 32'd0);
    @(negedge rgb_clk);
    idle(2);
    ack_hold = 1'b0; done_cnt = 0;
    rgb_rst_n = 1'b1;
    req_cycles = 0;
    lines(3, 10);
    idle(4);
    check("mrst_noreq", req_cycles, 0);
    req_log.delete(); uf_seen = 0;
    frame(10);
    check("mrst_nreq", req_log.size(), V);
    check("mrst_req0", 32'((req_log.size() > 0) ? req_log[0] : 12'hFFF), 32'({11'd0, 1'b0}));
    check("mrst_uf",   uf_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_line_fetch_ctrl.md
VIDEO_LINE_FETCH_CTRL -- requirements
Module: video_line_fetch_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 1280: active pixels per line, which is also the words per fetch.
REQ-002 Parameter V_ACTIVE, default 720: active lines per frame.
REQ-003 Parameter VS_POL, default 1: vsync assertion level (1 = positive, 0 = negative).
REQ-004 Port rgb_clk, input, 1 bit: pixel clock, the only clock; all logic updates on its rising edge.
REQ-005 Port rgb_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port ctrl_en, input, 1 bit: fetch enable, sampled at each frame start.
REQ-007 Port rgb_vs, input, 1 bit: vertical sync from the timing generator.
REQ-008 Port rgb_de, input, 1 bit: video valid from the timing generator.
REQ-009 Port fetch_req, output, 1 bit: line fetch request to the memory reader.
REQ-010 Port fetch_line, output, 11 bits: frame line number to fetch.
REQ-011 Port fetch_bank, output, 1 bit: ping-pong line-buffer bank to fill.
REQ-012 Port fetch_ack, input, 1 bit: request accepted.
REQ-013 Port fetch_done, input, 1 bit: single-cycle pulse when the line is written.
REQ-014 Port rd_bank, output, 1 bit: bank the display side reads for the current line.
REQ-015 Port underflow, output, 1 bit: single-cycle pulse on line start while the bank is not ready.
REQ-016 Port underflow_sticky, output, 1 bit: latched underflow.

Function
REQ-017 Frame start (FS) SHALL be detected as rgb_vs changing from !VS_POL to VS_POL, using a registered copy of rgb_vs.
REQ-018 Line start (LS) and line end (LE) SHALL be the rising and falling edges of rgb_de, detected from a registered copy of rgb_de.
REQ-019 State machine states SHALL be IDLE, REQ, WAIT_DONE and NEXT.
REQ-020 On FS with ctrl_en=1, the controller SHALL clear bank_valid[1:0], set rd_bank=0 and line counter ln=0, and queue fetches of line 0 to bank 0 and line 1 to bank 1.
REQ-021 On FS with ctrl_en=0, the controller SHALL clear bank_valid, clear the queue and remain in IDLE for the frame.
REQ-022 In REQ, fetch_req SHALL be 1, and fetch_line and fetch_bank SHALL hold stable until fetch_ack=1 is sampled; the FSM then moves to WAIT_DONE with fetch_req=0 on the next cycle.
REQ-023 In WAIT_DONE, fetch_done SHALL set bank_valid[fetch_bank] and move the FSM to NEXT.
REQ-024 In NEXT, the FSM SHALL go to REQ if a fetch is queued, otherwise to IDLE.
REQ-025 A fetch_done outside WAIT_DONE SHALL be ignored.
REQ-026 On LE, bank_valid[rd_bank] SHALL clear, rd_bank SHALL toggle and ln SHALL increment.
REQ-027 On LE, when ln+2 < V_ACTIVE, the controller SHALL queue a fetch of line ln+2 to the old rd_bank value.
REQ-028 The queue SHALL hold at most 2 entries; a queue request while the queue is full SHALL be dropped, and the resulting miss surfaces later as underflow.
REQ-029 On LS with bank_valid[rd_bank]=0, underflow SHALL pulse for 1 cycle and underflow_sticky SHALL set.
REQ-030 An FS arriving during REQ or WAIT_DONE SHALL NOT drop fetch_req before fetch_ack; the outstanding transfer SHALL complete, its fetch_done SHALL be discarded, and the frame restart of REQ-020 SHALL then apply.
REQ-031 When LE and fetch_done occur in the same cycle on the same bank, the clear SHALL take priority over the set.
REQ-032 ln SHALL saturate at V_ACTIVE-1.
REQ-033 fetch_line SHALL be 11 bits with no wrap.
REQ-034 underflow_sticky SHALL clear only on reset.

Reset
REQ-035 While rgb_rst_n=0, the FSM SHALL be in IDLE.
REQ-036 While rgb_rst_n=0, fetch_req, fetch_line, fetch_bank, rd_bank, underflow, underflow_sticky, bank_valid, the queue and ln SHALL be 0, and the edge registers SHALL be !VS_POL and 0.
REQ-037 A reset asserted mid-fetch SHALL drop fetch_req immediately.
REQ-038 After reset, the block SHALL issue no request until the first FS.

Configuration
REQ-039 Macro FETCH_ERR_CNT_EN, when defined, SHALL add output port underflow_cnt[15:0].
REQ-040 underflow_cnt SHALL increment on each underflow pulse, saturate at 16'hFFFF, and reset to 0.
REQ-041 When FETCH_ERR_CNT_EN is undefined, the port and counter SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-042 Ideal reader (ack 1 cycle after req, done 1400 cycles later), 720p frame -> exactly 720 requests with lines 0..719 and banks alternating 0,1,0,...; underflow never asserted.
REQ-043 ctrl_en=0 at FS -> no fetch_req for the frame, and every LS pulses underflow (720 pulses); with FETCH_ERR_CNT_EN defined, underflow_cnt=720.
REQ-044 fetch_ack held at 0 for 5000 cycles -> fetch_req, fetch_line=0 and fetch_bank=0 stay stable throughout; the first LS pulses underflow.
REQ-045 FS injected during WAIT_DONE of line 300 -> fetch_req held until ack; the stale done is discarded; the next request is line 0, bank 0; rd_bank=0.
REQ-046 rgb_rst_n pulsed low mid-REQ -> fetch_req=0 and underflow_sticky=0 in the same cycle; no request until the next FS.
REQ-047 LE and fetch_done on the same bank in one cycle -> bank_valid for that bank reads 0 on the next cycle.
